// File: rtl/alu_pkg.sv
// Shared constants for the ALU result buffer: source tags, default width,
// and the priority/collision helpers used by the capture logic.
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int NUM_SRC            = 4;

  localparam logic [1:0] SRC_ARITH = 2'b00;
  localparam logic [1:0] SRC_LOGIC = 2'b01;
  localparam logic [1:0] SRC_CMP   = 2'b10;
  localparam logic [1:0] SRC_SHIFT = 2'b11;

  // Flag vector bit order: [0] arith, [1] logic, [2] cmp, [3] shift.
  function automatic logic [1:0] pick_src(input logic [NUM_SRC-1:0] f);
    if (f[0])      return SRC_ARITH;
    else if (f[1]) return SRC_LOGIC;
    else if (f[2]) return SRC_CMP;
    else           return SRC_SHIFT;
  endfunction

  function automatic logic multi_hot(input logic [NUM_SRC-1:0] f);
    return (f & (f - NUM_SRC'(1))) != '0;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Result storage ring for alu_result_buffer: DEPTH entries, power-of-two
// pointers that wrap naturally, occupancy counter with async active-low reset.
module alu_res_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_logic,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push;

  assign full = (count == CW'(DEPTH));
  // Guard locally too, so the ring can never underflow or overrun.
  assign pop  = rd_en && (count != '0);
  assign push = wr_en && (!full || pop);

  // Head reads as zero while empty, which also covers the reset state.
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_logic) begin
    if (!rst_logic) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Collects results from four ALU units into an in-order FIFO with priority
// capture and sticky error flags. Define ALU_RESULT_TAG_EN to add res_tag.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_logic,
  input  logic [DATA_WIDTH-1:0] arith_out,
  input  logic [DATA_WIDTH-1:0] logic_out,
  input  logic [DATA_WIDTH-1:0] cmp_out,
  input  logic [DATA_WIDTH-1:0] shift_out,
  input  logic                  arith_flag,
  input  logic                  logic_flag,
  input  logic                  cmp_flag,
  input  logic                  shift_flag,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  overflow_err,
  output logic                  collision_err
`ifdef ALU_RESULT_TAG_EN
  ,
  output logic [1:0]            res_tag
`endif
);

`ifdef ALU_RESULT_TAG_EN
  localparam int EW = DATA_WIDTH + 2;
`else
  localparam int EW = DATA_WIDTH;
`endif

  logic [NUM_SRC-1:0]                 flag_d;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;
  logic [1:0]                         sel;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic [EW-1:0]                      wr_entry, rd_entry;
  logic                               wr_req, pop, wr_en;

  // Flags lead their data by one cycle; delaying them aligns flag and data.
  always_ff @(posedge clk or negedge rst_logic) begin
    if (!rst_logic) flag_d <= '0;
    else            flag_d <= {shift_flag, cmp_flag, logic_flag, arith_flag};
  end

  assign src_data = {shift_out, cmp_out, logic_out, arith_out};
  assign sel      = pick_src(flag_d);
  assign wr_data  = src_data[sel];

  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign wr_req    = |flag_d;
  assign wr_en     = wr_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_logic) begin
    if (!rst_logic) begin
      overflow_err  <= 1'b0;
      collision_err <= 1'b0;
    end else begin
      if (wr_req && full && !pop) overflow_err  <= 1'b1;
      if (multi_hot(flag_d))      collision_err <= 1'b1;
    end
  end

`ifdef ALU_RESULT_TAG_EN
  assign wr_entry = {sel, wr_data};
  assign res_data = rd_entry[DATA_WIDTH-1:0];
  assign res_tag  = rd_entry[EW-1 -: 2];
`else
  assign wr_entry = wr_data;
  assign res_data = rd_entry;
`endif

  alu_res_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_logic (rst_logic),
    .wr_en     (wr_en),
    .wr_data   (wr_entry),
    .rd_en     (pop),
    .rd_data   (rd_entry),
    .count     (count),
    .full      (full)
  );

endmodule
